// File: rtl/imm_gen_pipe_if.sv
// Handshake bus for the pipelined immediate generator: instruction-in side
// and immediate-out side, each with its own valid/ready pair.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    // Producer of instructions and consumer of immediates
    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

    // The immediate generator stage itself
    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator. Decodes I/S/B/U/J immediates by the
// full 7-bit opcode, sign-extends to XLEN, flags unknown opcodes and counts
// them. One registered stage with a skid buffer so in_ready is a pure flop.
module imm_gen_pipe #(
    parameter int XLEN    = 64,
    parameter int TAG_W   = 8,
    parameter int B_SHIFT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    imm_gen_pipe_if.slave    bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] illegal_cnt
);
    localparam logic [2:0] FMT_I    = 3'd0;
    localparam logic [2:0] FMT_S    = 3'd1;
    localparam logic [2:0] FMT_B    = 3'd2;
    localparam logic [2:0] FMT_U    = 3'd3;
    localparam logic [2:0] FMT_J    = 3'd4;
    localparam logic [2:0] FMT_NONE = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } res_t;

    localparam res_t RES_RST = '{imm: {XLEN{1'b0}}, fmt: FMT_NONE, ill: 1'b0, tag: {TAG_W{1'b0}}};

    logic [31:0]      instr_s;
    logic [63:0]      dec_imm64_s;
    logic [2:0]       dec_fmt_s;
    logic             dec_ill_s;
    res_t             dec_s;
    logic             in_xfer_s;
    logic             out_xfer_s;

    res_t             out_q, out_d;
    res_t             skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign instr_s    = bus.in_instr;
    assign in_xfer_s  = bus.in_valid & in_ready_q;
    assign out_xfer_s = out_valid_q & bus.out_ready;

    // Opcode decode; every immediate is built at 64 bits and trimmed to XLEN
    always_comb begin
        dec_imm64_s = 64'd0;
        dec_fmt_s   = FMT_NONE;
        dec_ill_s   = 1'b1;
        case (instr_s[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: begin
                dec_imm64_s = {{52{instr_s[31]}}, instr_s[31:20]};
                dec_fmt_s   = FMT_I;
                dec_ill_s   = 1'b0;
            end
            7'b0100011: begin
                dec_imm64_s = {{52{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
                dec_fmt_s   = FMT_S;
                dec_ill_s   = 1'b0;
            end
            7'b1100011: begin
                if (B_SHIFT != 0) begin
                    dec_imm64_s = {{51{instr_s[31]}}, instr_s[31], instr_s[7],
                                   instr_s[30:25], instr_s[11:8], 1'b0};
                end else begin
                    dec_imm64_s = {{52{instr_s[31]}}, instr_s[31], instr_s[7],
                                   instr_s[30:25], instr_s[11:8]};
                end
                dec_fmt_s = FMT_B;
                dec_ill_s = 1'b0;
            end
            7'b0110111, 7'b0010111: begin
                dec_imm64_s = {{32{instr_s[31]}}, instr_s[31:12], 12'h000};
                dec_fmt_s   = FMT_U;
                dec_ill_s   = 1'b0;
            end
            7'b1101111: begin
                dec_imm64_s = {{43{instr_s[31]}}, instr_s[31], instr_s[19:12],
                               instr_s[20], instr_s[30:21], 1'b0};
                dec_fmt_s   = FMT_J;
                dec_ill_s   = 1'b0;
            end
            default: begin
                dec_imm64_s = 64'd0;
                dec_fmt_s   = FMT_NONE;
                dec_ill_s   = 1'b1;
            end
        endcase
    end

    assign dec_s = '{imm: dec_imm64_s[XLEN-1:0], fmt: dec_fmt_s, ill: dec_ill_s, tag: bus.in_tag};

    // Output/skid steering: skid drains first, so ordering is preserved
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || out_xfer_s) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_xfer_s) begin
                out_d       = dec_s;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            if (in_xfer_s) begin
                skid_d       = dec_s;
                skid_valid_d = 1'b1;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
        in_ready_d = !skid_valid_d;
    end

    // Saturating illegal-opcode counter; clear beats increment
    always_comb begin
        if (cnt_clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (in_xfer_s && dec_ill_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q        <= RES_RST;
            skid_q       <= RES_RST;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            cnt_q        <= {CNT_W{1'b0}};
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_fmt     = out_q.fmt;
    assign bus.out_illegal = out_q.ill;
    assign bus.out_tag     = out_q.tag;
    assign illegal_cnt     = cnt_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe. Two instances: A (XLEN=64, B_SHIFT=1,
// CNT_W=16) and B (XLEN=32, B_SHIFT=0, CNT_W=2). Accepted instructions are
// decoded by an arithmetic reference model and queued; a negedge monitor
// pops and compares on every output transfer.
module tb_imm_gen_pipe;
    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [7:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic cnt_clr = 1'b0;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;
    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(64), .TAG_W(8)) bus_a ();
    imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) bus_b ();

    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .B_SHIFT(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave), .cnt_clr(cnt_clr), .illegal_cnt(cnt_a));
    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .B_SHIFT(0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave), .cnt_clr(cnt_clr), .illegal_cnt(cnt_b));

    // Driven inputs and observed outputs, indexed by instance
    logic        d_iv[2];
    logic [31:0] d_instr[2];
    logic [7:0]  d_tag[2];
    logic        d_ordy[2];
    logic        m_ir[2], m_ov[2], m_ill[2];
    logic [63:0] m_imm[2];
    logic [2:0]  m_fmt[2];
    logic [7:0]  m_otag[2];
    logic [15:0] m_cnt[2];

    assign bus_a.in_valid = d_iv[0];    assign bus_b.in_valid = d_iv[1];
    assign bus_a.in_instr = d_instr[0]; assign bus_b.in_instr = d_instr[1];
    assign bus_a.in_tag   = d_tag[0];   assign bus_b.in_tag   = d_tag[1];
    assign bus_a.out_ready = d_ordy[0]; assign bus_b.out_ready = d_ordy[1];
    assign m_ir[0] = bus_a.in_ready;     assign m_ir[1] = bus_b.in_ready;
    assign m_ov[0] = bus_a.out_valid;    assign m_ov[1] = bus_b.out_valid;
    assign m_ill[0] = bus_a.out_illegal; assign m_ill[1] = bus_b.out_illegal;
    assign m_imm[0] = bus_a.out_imm;     assign m_imm[1] = {32'h0, bus_b.out_imm};
    assign m_fmt[0] = bus_a.out_fmt;     assign m_fmt[1] = bus_b.out_fmt;
    assign m_otag[0] = bus_a.out_tag;    assign m_otag[1] = bus_b.out_tag;
    assign m_cnt[0] = cnt_a;             assign m_cnt[1] = {14'd0, cnt_b};

    int checks = 0;
    int failures = 0;
    int or_mode[2];          // 0 random, 1 held high, 2 held low
    bit mon_en = 1'b0;
    exp_t sbq[2][$];
    int cm[2];
    bit stall_prev[2];
    exp_t held[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference decode from the ISA field definitions using integer arithmetic
    function automatic exp_t ref_dec(input logic [31:0] i, input int xlen, input int bshift);
        exp_t e;
        longint v;
        v = 0; e.fmt = 3'd7; e.ill = 1'b1; e.tag = 8'd0;
        case (i[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: begin
                v = longint'($signed(i[31:20])); e.fmt = 3'd0; e.ill = 1'b0;
            end
            7'b0100011: begin
                v = longint'($signed({i[31:25], i[11:7]})); e.fmt = 3'd1; e.ill = 1'b0;
            end
            7'b1100011: begin
                v = longint'($signed({i[31], i[7], i[30:25], i[11:8]}));
                if (bshift != 0) v = v * 2;
                e.fmt = 3'd2; e.ill = 1'b0;
            end
            7'b0110111, 7'b0010111: begin
                v = longint'($signed(i[31:12])) * 4096; e.fmt = 3'd3; e.ill = 1'b0;
            end
            7'b1101111: begin
                v = longint'($signed({i[31], i[19:12], i[20], i[30:21]})) * 2;
                e.fmt = 3'd4; e.ill = 1'b0;
            end
            default: ;
        endcase
        e.imm = v;
        if (xlen == 32) e.imm[63:32] = 32'h0;
        return e;
    endfunction

    // Consumer ready generation, changed away from the clock edge
    initial begin
        or_mode[0] = 1; or_mode[1] = 1;
        d_ordy[0] = 1'b1; d_ordy[1] = 1'b1;
        forever begin
            @(posedge clk); #2;
            for (int d = 0; d < 2; d++)
                d_ordy[d] = (or_mode[d] == 0) ? 1'($urandom_range(0, 1)) : (or_mode[d] == 1);
        end
    end

    // Monitor: occupancy invariants, counter model, stall stability, scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                automatic exp_t e;
                automatic exp_t n;
                automatic int cmax = (d == 0) ? 65535 : 3;
                chk($sformatf("out_valid_occ%0d", d), m_ov[d], sbq[d].size() > 0);
                chk($sformatf("in_ready_occ%0d", d), m_ir[d], sbq[d].size() < 2);
                chk($sformatf("illegal_cnt%0d", d), m_cnt[d], cm[d]);
                if (stall_prev[d] && m_ov[d]) begin
                    chk($sformatf("stall_imm%0d", d), m_imm[d], held[d].imm);
                    chk($sformatf("stall_fmt%0d", d), m_fmt[d], held[d].fmt);
                    chk($sformatf("stall_tag%0d", d), m_otag[d], held[d].tag);
                end
                if (!reset) begin
                    sbq[d].delete();
                    cm[d] <= 0;
                    stall_prev[d] <= 1'b0;
                end else begin
                    if (m_ov[d] && d_ordy[d] && sbq[d].size() > 0) begin
                        e = sbq[d].pop_front();
                        chk($sformatf("imm%0d", d), m_imm[d], e.imm);
                        chk($sformatf("fmt%0d", d), m_fmt[d], e.fmt);
                        chk($sformatf("illegal%0d", d), m_ill[d], e.ill);
                        chk($sformatf("tag%0d", d), m_otag[d], e.tag);
                    end
                    n = ref_dec(d_instr[d], (d == 0) ? 64 : 32, (d == 0) ? 1 : 0);
                    if (d_iv[d] && m_ir[d]) begin
                        n.tag = d_tag[d];
                        sbq[d].push_back(n);
                    end
                    if (cnt_clr) cm[d] <= 0;
                    else if (d_iv[d] && m_ir[d] && n.ill && cm[d] != cmax) cm[d] <= cm[d] + 1;
                    else cm[d] <= cm[d];
                    stall_prev[d] <= m_ov[d] && !d_ordy[d];
                    held[d] <= '{imm: m_imm[d], fmt: m_fmt[d], ill: m_ill[d], tag: m_otag[d]};
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Present one instruction and hold it until the stage accepts it
    task automatic send(input int d, input logic [31:0] instr, input logic [7:0] tag);
        logic r;
        bit ok;
        ok = 1'b0;
        d_iv[d] = 1'b1; d_instr[d] = instr; d_tag[d] = tag;
        for (int k = 0; k < 64 && !ok; k++) begin
            r = m_ir[d];
            @(posedge clk); #1;
            if (r) ok = 1'b1;
        end
        d_iv[d] = 1'b0; d_instr[d] = $urandom; d_tag[d] = 8'($urandom);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout%0d: accepted=0 required=1", d);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0] ops [9];
        int k;
        ops = '{7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b0100011,
                7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
        r = $urandom;
        k = $urandom_range(0, 10);
        if (k < 9) r[6:0] = ops[k];
        return r;
    endfunction

    task automatic random_phase(input int d, input int n);
        for (int k = 0; k < n; k++) begin
            send(d, rand_instr(), 8'(k));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: finished=0 required=1");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            d_iv[d] = 1'b0; d_instr[d] = 32'h0; d_tag[d] = 8'h0;
            cm[d] = 0; stall_prev[d] = 1'b0;
        end
        reset = 1'b0;
        idle(3);
        mon_en = 1'b1;
        chk("rst_out_valid", bus_a.out_valid, 64'd0);
        chk("rst_in_ready", bus_a.in_ready, 64'd1);
        chk("rst_out_imm", bus_a.out_imm, 64'd0);
        chk("rst_out_fmt", bus_a.out_fmt, 64'd7);
        chk("rst_out_illegal", bus_a.out_illegal, 64'd0);
        chk("rst_out_tag", bus_a.out_tag, 64'd0);
        chk("rst_cnt", cnt_a, 64'd0);
        reset = 1'b1;
        idle(2);

        // Directed decode vectors, consumer always ready
        send(0, 32'hFF813283, 8'd1); chk("ld_imm", bus_a.out_imm, 64'hFFFFFFFFFFFFFFF8);
        chk("ld_fmt", bus_a.out_fmt, 64'd0); chk("ld_ill", bus_a.out_illegal, 64'd0);
        send(0, 32'h00613823, 8'd2); chk("sd_imm", bus_a.out_imm, 64'h10);
        chk("sd_fmt", bus_a.out_fmt, 64'd1);
        send(0, 32'hFE000EE3, 8'd3); chk("beq_imm", bus_a.out_imm, 64'hFFFFFFFFFFFFFFFC);
        chk("beq_fmt", bus_a.out_fmt, 64'd2);
        send(0, 32'h800000B7, 8'd4); chk("lui_imm", bus_a.out_imm, 64'hFFFFFFFF80000000);
        chk("lui_fmt", bus_a.out_fmt, 64'd3);
        send(0, 32'h001000EF, 8'd5); chk("jal_imm", bus_a.out_imm, 64'h800);
        chk("jal_fmt", bus_a.out_fmt, 64'd4);
        send(1, 32'hFE000EE3, 8'd6); chk("beq_legacy_imm", bus_b.out_imm, 64'hFFFFFFFE);
        send(1, 32'h800000B7, 8'd7); chk("lui32_imm", bus_b.out_imm, 64'h80000000);
        idle(2);

        // Back-to-back tags 1..6 with a three-cycle consumer stall
        fork
            for (int t = 1; t <= 6; t++) send(0, rand_instr(), 8'(t));
            begin idle(2); or_mode[0] = 2; idle(3); or_mode[0] = 1; end
        join
        idle(4);

        // Illegal counter: three increments, then clear wins over a fourth
        cnt_clr = 1'b1; idle(1); cnt_clr = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            send(0, 32'h00000000, 8'(8'h40 + k));
            chk("cnt_step", cnt_a, 64'(k));
        end
        chk("ill_flag", bus_a.out_illegal, 64'd1);
        chk("ill_imm", bus_a.out_imm, 64'd0);
        chk("ill_fmt", bus_a.out_fmt, 64'd7);
        cnt_clr = 1'b1;
        send(0, 32'h00000000, 8'h44);
        cnt_clr = 1'b0;
        chk("cnt_clr_wins", cnt_a, 64'd0);
        for (int k = 0; k < 5; k++) send(1, 32'h0000007F, 8'(k));
        chk("cnt_saturate", cnt_b, 64'd3);
        idle(3);

        // Randomised traffic with random backpressure on both instances
        or_mode[0] = 0; or_mode[1] = 0;
        fork
            random_phase(0, 150);
            random_phase(1, 150);
            repeat (6) begin idle($urandom_range(20, 60)); cnt_clr = 1'b1; idle(1); cnt_clr = 1'b0; end
        join
        or_mode[0] = 1; or_mode[1] = 1;
        idle(6);

        // Reset while the skid holds a result and the output is stalled
        or_mode[0] = 2;
        idle(2);
        send(0, 32'h00000000, 8'hA1);
        send(0, 32'h00000000, 8'hA2);
        idle(1);
        chk("skid_full_in_ready", bus_a.in_ready, 64'd0);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        chk("post_rst_out_valid", bus_a.out_valid, 64'd0);
        chk("post_rst_in_ready", bus_a.in_ready, 64'd1);
        chk("post_rst_cnt", cnt_a, 64'd0);
        chk("post_rst_fmt", bus_a.out_fmt, 64'd7);
        or_mode[0] = 1;
        send(0, 32'h001000EF, 8'hB0);
        idle(2);

        // Drain: everything accepted must have come out
        for (int k = 0; k < 20 && (sbq[0].size() + sbq[1].size()) != 0; k++) idle(1);
        chk("drain_a", sbq[0].size(), 64'd0);
        chk("drain_b", sbq[1].size(), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
